dec_n_scan: RTL and testbench

//   Parametrised registered N-to-2^N one-hot decoder with valid/ready input handshake,

---
 rtl/dec_n_scan_pkg.sv | 21 ++
 rtl/dec_n_scan_if.sv | 26 ++
 rtl/dec_n_scan_onehot.sv | 13 +
 rtl/dec_n_scan.sv | 126 ++++++++++++
 tb/tb_dec_n_scan.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/dec_n_scan_pkg.sv
// Shared types and helpers for the dec_n_scan one-hot decoder/scanner.
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  localparam int N_DEF = 4;
  localparam int OUT_W = 1 << N_DEF;

  function automatic int out_w(input int n);
    return 1 << n;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/dec_n_scan_if.sv
// Select handshake, dwell and one-hot output bundle for dec_n_scan.
interface dec_n_scan_if #(
  parameter int N  = 4,
  parameter int DW = 4
);
  logic                en;
  logic                mode;
  logic [N-1:0]        sel;
  logic                sel_valid;
  logic                sel_ready;
  logic [DW-1:0]       dwell;
  logic [(1<<N)-1:0]   y;
  logic                y_valid;
  logic [N-1:0]        scan_idx;
  logic                scan_wrap;

  modport master (
    output en, mode, sel, sel_valid, dwell,
    input  sel_ready, y, y_valid, scan_idx, scan_wrap
  );

  modport slave (
    input  en, mode, sel, sel_valid, dwell,
    output sel_ready, y, y_valid, scan_idx, scan_wrap
  );
endinterface

// File: rtl/dec_n_scan_onehot.sv
// Pure combinational N -> 2^N one-hot decoder.
module dec_onehot
  import dec_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          sel_i,
  output logic [out_w(N)-1:0]   y_o
);
  localparam int OW = out_w(N);

  assign y_o = OW'(1) << sel_i;
endmodule

// File: rtl/dec_n_scan.sv
// Registered one-hot decoder with dwell timer and autonomous scan mode.
// Define GRAY_SCAN_EN to walk the scan in Gray-code order instead of binary.
module dec_n_scan
  import dec_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dec_n_scan_if.slave   bus
);
  localparam int OW = out_w(N);
  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_HOLD = 2'(HOLD);
  localparam logic [1:0] S_SCAN = 2'(SCAN);

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  idx_q, idx_d;
  logic [N-1:0]  cntb_q, cntb_d, cntb_inc, scan_next;
  logic [OW-1:0] y_q, y_d, oh;
  logic          yv_q, yv_d, wrap_q, wrap_d, rdy_q, accept;

  assign cntb_inc = cntb_q + N'(1);

`ifdef GRAY_SCAN_EN
  assign scan_next = N'(bin2gray(32'(cntb_inc)));
`else
  assign scan_next = cntb_inc;
`endif

  // rdy_q means "sitting in IDLE"; it is low for the first cycle out of reset
  assign bus.sel_ready = rdy_q & bus.en & ~bus.mode;
  assign accept        = bus.sel_ready & bus.sel_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    cntb_d  = cntb_q;
    yv_d    = yv_q;
    wrap_d  = 1'b0;
    if (!bus.en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      yv_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.mode) begin
            state_d = S_SCAN;
            cntb_d  = '0;
            idx_d   = '0;
            cnt_d   = bus.dwell;
            yv_d    = 1'b1;
          end else if (accept) begin
            state_d = S_HOLD;
            idx_d   = bus.sel;
            cnt_d   = bus.dwell;
            yv_d    = 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            yv_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - DW'(1);
          end
        end
        S_SCAN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DW'(1);
          end else if (!bus.mode) begin
            state_d = S_IDLE;
            yv_d    = 1'b0;
          end else begin
            cntb_d = cntb_inc;
            idx_d  = scan_next;
            cnt_d  = bus.dwell;
            wrap_d = (cntb_q == '1);
          end
        end
        default: begin
          state_d = S_IDLE;
          yv_d    = 1'b0;
        end
      endcase
    end
  end

  dec_onehot #(.N(N)) u_onehot (
    .sel_i (idx_d),
    .y_o   (oh)
  );

  assign y_d = yv_d ? oh : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      cntb_q  <= '0;
      y_q     <= '0;
      yv_q    <= 1'b0;
      wrap_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cntb_q  <= cntb_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      wrap_q  <= wrap_d;
      rdy_q   <= (state_d == S_IDLE);
    end
  end

  assign bus.y         = y_q;
  assign bus.y_valid   = yv_q;
  assign bus.scan_idx  = idx_q;
  assign bus.scan_wrap = wrap_q;
endmodule

// File: tb/tb_dec_n_scan.sv
// Directed scoreboard bench for dec_n_scan (N=4, DW=4).
module tb_dec_n_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b1;

  dec_n_scan_if #(.N(4), .DW(4)) bus ();

  dec_n_scan #(.N(4), .DW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] y;
    logic        yv;
    logic [3:0]  idx;
    logic        wrap;
    logic        rdy;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [3:0] ord(input int k);
    logic [3:0] b;
    b = 4'(k % 16);
`ifdef GRAY_SCAN_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] i);
    return 16'(1) << i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [15:0] y, input logic yv, input logic [3:0] idx,
                      input logic wrap, input logic rdy);
    exp_t e;
    e.y = y; e.yv = yv; e.idx = idx; e.wrap = wrap; e.rdy = rdy;
    q.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    assert (q.size() > 0) else begin
      errors++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, ".y"},         32'(bus.y),         32'(e.y));
      chk({tag, ".y_valid"},   32'(bus.y_valid),   32'(e.yv));
      chk({tag, ".scan_idx"},  32'(bus.scan_idx),  32'(e.idx));
      chk({tag, ".scan_wrap"}, 32'(bus.scan_wrap), 32'(e.wrap));
      chk({tag, ".sel_ready"}, 32'(bus.sel_ready), 32'(e.rdy));
    end
  endtask

  initial begin
    bus.en = 1'b1; bus.mode = 1'b0; bus.sel = '0; bus.sel_valid = 1'b0; bus.dwell = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst.y", 32'(bus.y), 32'h0);
    chk("rst.y_valid", 32'(bus.y_valid), 32'h0);
    chk("rst.scan_idx", 32'(bus.scan_idx), 32'h0);
    chk("rst.sel_ready", 32'(bus.sel_ready), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    push(16'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    tick("post_rst");

    // decode, dwell 0: single-cycle pulse
    bus.sel = 4'h5; bus.sel_valid = 1'b1; bus.dwell = 4'd0;
    push(16'h0020, 1'b1, 4'h5, 1'b0, 1'b0);
    tick("dec5");
    bus.sel_valid = 1'b0;
    push(16'h0, 1'b0, 4'h5, 1'b0, 1'b1);
    tick("dec5_end");
    push(16'h0, 1'b0, 4'h5, 1'b0, 1'b1);
    tick("dec5_idle");

    // decode, dwell 3: four cycles, mid-slot dwell change ignored
    bus.sel = 4'hF; bus.sel_valid = 1'b1; bus.dwell = 4'd3;
    push(16'h8000, 1'b1, 4'hF, 1'b0, 1'b0);
    tick("dwell0");
    bus.sel_valid = 1'b0; bus.dwell = 4'd0;
    for (int i = 1; i < 4; i++) begin
      push(16'h8000, 1'b1, 4'hF, 1'b0, 1'b0);
      tick("dwell_hold");
    end
    push(16'h0, 1'b0, 4'hF, 1'b0, 1'b1);
    tick("dwell_end");

    // scan with sel_valid in the same cycle: scan wins, sel not accepted
    bus.mode = 1'b1; bus.dwell = 4'd1; bus.sel = 4'hA; bus.sel_valid = 1'b1;
    push(oh(ord(0)), 1'b1, ord(0), 1'b0, 1'b0);
    tick("scan_entry");
    bus.sel_valid = 1'b0;
    for (int k = 0; k < 18; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (!(k == 0 && c == 0)) begin
          push(oh(ord(k)), 1'b1, ord(k), (k == 16 && c == 0), 1'b0);
          tick("scan");
        end
        if (k == 17 && c == 0) bus.mode = 1'b0;
      end
    end
    push(16'h0, 1'b0, ord(17), 1'b0, 1'b1);
    tick("scan_stop");

    // abort with en=0 during slot 7
    bus.mode = 1'b1; bus.dwell = 4'd1;
    push(oh(ord(0)), 1'b1, ord(0), 1'b0, 1'b0);
    tick("abort_entry");
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (!(k == 0 && c == 0) && !(k == 7 && c == 1)) begin
          push(oh(ord(k)), 1'b1, ord(k), 1'b0, 1'b0);
          tick("abort_scan");
        end
      end
    end
    bus.en = 1'b0;
    push(16'h0, 1'b0, ord(7), 1'b0, 1'b0);
    tick("abort");
    push(16'h0, 1'b0, ord(7), 1'b0, 1'b0);
    tick("abort_idle");

    // async reset in the middle of a HOLD slot
    bus.en = 1'b1; bus.mode = 1'b0; bus.sel = 4'h3; bus.dwell = 4'd5; bus.sel_valid = 1'b1;
    push(16'h0008, 1'b1, 4'h3, 1'b0, 1'b0);
    tick("hold3");
    bus.sel_valid = 1'b0;
    push(16'h0008, 1'b1, 4'h3, 1'b0, 1'b0);
    tick("hold3_b");
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.y", 32'(bus.y), 32'h0);
    chk("midrst.y_valid", 32'(bus.y_valid), 32'h0);
    chk("midrst.scan_idx", 32'(bus.scan_idx), 32'h0);
    chk("midrst.sel_ready", 32'(bus.sel_ready), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    push(16'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    tick("midrst_idle");

    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain observed=%0d expected=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
